// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - shared VGA 640x480@60 timing constants
// Purpose: timing geometry shared by the timing generator and the screen
//          renderers, plus the coordinate width and a divider-width helper.
// Ports:   none (package).
package vga_timing_gen_pkg;

  localparam int COORD_W = 10;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Sync windows are inclusive on both ends.
  localparam int HSYNC_START = H_DISPLAY + H_FRONT;
  localparam int HSYNC_END   = HSYNC_START + H_SYNC - 1;
  localparam int VSYNC_START = V_DISPLAY + V_FRONT;
  localparam int VSYNC_END   = VSYNC_START + V_SYNC - 1;

  localparam int CLK_DIV = 4;

  // Width of a counter that cycles through 0..n-1, never less than one bit.
  function automatic int div_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pix_tick_div.sv
// rtl/pix_tick_div.sv - pixel-rate enable divider
// Purpose: free-running CLK_DIV counter producing a registered one-cycle
//          pixel enable every CLK_DIV system clocks.
// Ports:   clk_100MHz (in)  system clock
//          reset      (in)  asynchronous, active-high
//          p_tick     (out) pixel enable, first pulse CLK_DIV clocks after reset
module pix_tick_div
  import vga_timing_gen_pkg::*;
#(
  parameter int CLK_DIV = vga_timing_gen_pkg::CLK_DIV
) (
  input  logic clk_100MHz,
  input  logic reset,
  output logic p_tick
);

  localparam int                DIV_W    = div_width(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] r_div;
  logic             r_p_tick;

  // CLK_DIV is a power of two, so the counter wraps on its own.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_div    <= '0;
      r_p_tick <= 1'b0;
    end else begin
      r_div    <= r_div + DIV_ONE;
      r_p_tick <= (r_div == DIV_LAST);
    end
  end

  assign p_tick = r_p_tick;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with frame strobes
// Purpose: pixel/line counters, registered syncs and video_on, plus a
//          per-frame strobe, pause-gated game tick and frame counter.
// Ports:   clk_100MHz  (in)  system clock
//          reset       (in)  asynchronous, active-high
//          pause       (in)  suppresses game_tick only
//          p_tick      (out) pixel enable
//          x, y        (out) current pixel column / line
//          video_on    (out) visible-area flag
//          hsync/vsync (out) active-low syncs
//          frame_tick  (out) one-clock pulse entering vertical blank
//          game_tick   (out) frame_tick gated by pause
//          frame_count (out) free-running 8-bit frame counter
module vga_timing_gen #(
  parameter int H_DISPLAY = vga_timing_gen_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_gen_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_gen_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_gen_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_gen_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_gen_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_gen_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_gen_pkg::V_BACK,
  parameter int CLK_DIV   = vga_timing_gen_pkg::CLK_DIV
) (
  input  logic                                   clk_100MHz,
  input  logic                                   reset,
  input  logic                                   pause,
  output logic                                   p_tick,
  output logic [vga_timing_gen_pkg::COORD_W-1:0] x,
  output logic [vga_timing_gen_pkg::COORD_W-1:0] y,
  output logic                                   video_on,
  output logic                                   hsync,
  output logic                                   vsync,
  output logic                                   frame_tick,
  output logic                                   game_tick,
  output logic [7:0]                             frame_count
);

  localparam int CW = vga_timing_gen_pkg::COORD_W;

  localparam logic [CW-1:0] X_LAST   = CW'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CW-1:0] X_VIS    = CW'(H_DISPLAY);
  localparam logic [CW-1:0] Y_VIS    = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [CW-1:0] Y_PRE_VB = CW'(V_DISPLAY - 1);
  localparam logic [CW-1:0] CO_ONE   = CW'(1);

  logic          w_p_tick;
  logic          w_x_last;
  logic          w_y_last;
  logic          w_frame_edge;
  logic [CW-1:0] w_x_next;
  logic [CW-1:0] w_y_next;

  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_video_on;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_frame_tick;
  logic          r_game_tick;
  logic [7:0]    r_frame_count;

  pix_tick_div #(
    .CLK_DIV    (CLK_DIV)
  ) u_pix_tick_div (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .p_tick     (w_p_tick)
  );

  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);

  // The advancing edge from the last pixel of the last visible line lands
  // the counters on (0, V_DISPLAY): the start of vertical blank.
  assign w_frame_edge = w_p_tick && w_x_last && (r_y == Y_PRE_VB);

  always_comb begin
    w_x_next = r_x;
    w_y_next = r_y;
    if (w_p_tick) begin
      if (w_x_last) begin
        w_x_next = '0;
        w_y_next = w_y_last ? '0 : (r_y + CO_ONE);
      end else begin
        w_x_next = r_x + CO_ONE;
      end
    end
  end

  // Decode from the next-state counters so syncs and video_on always
  // describe the x/y that are on the outputs in the same cycle.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_x           <= '0;
      r_y           <= '0;
      r_video_on    <= 1'b1;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_tick  <= 1'b0;
      r_game_tick   <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_x          <= w_x_next;
      r_y          <= w_y_next;
      r_video_on   <= (w_x_next < X_VIS) && (w_y_next < Y_VIS);
      r_hsync      <= !((w_x_next >= HS_FIRST) && (w_x_next <= HS_LAST));
      r_vsync      <= !((w_y_next >= VS_FIRST) && (w_y_next <= VS_LAST));
      r_frame_tick <= w_frame_edge;
      r_game_tick  <= w_frame_edge && !pause;
      if (w_frame_edge) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign p_tick      = w_p_tick;
  assign x           = r_x;
  assign y           = r_y;
  assign video_on    = r_video_on;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_tick  = r_frame_tick;
  assign game_tick   = r_game_tick;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  // Reduced geometry for the cycle-exact instance.
  localparam int DIV = 4;
  localparam int HD = 4, HF = 2, HS = 2, HB = 2, HT = HD + HF + HS + HB;
  localparam int VD = 3, VF = 1, VS = 2, VB = 1, VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int VB_PIX = VD * HT;

  logic clk_100MHz = 1'b0;
  logic reset = 1'b1;
  logic pause = 1'b0;

  logic       s_p_tick, s_video_on, s_hsync, s_vsync, s_frame_tick, s_game_tick;
  logic [9:0] s_x, s_y;
  logic [7:0] s_frame_count;
  logic       f_p_tick, f_video_on, f_hsync, f_vsync, f_frame_tick, f_game_tick;
  logic [9:0] f_x, f_y;
  logic [7:0] f_frame_count;

  always #5 clk_100MHz = ~clk_100MHz;

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CLK_DIV(DIV)
  ) u_dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .pause(pause),
    .p_tick(s_p_tick), .x(s_x), .y(s_y), .video_on(s_video_on),
    .hsync(s_hsync), .vsync(s_vsync), .frame_tick(s_frame_tick),
    .game_tick(s_game_tick), .frame_count(s_frame_count)
  );

  vga_timing_gen u_dut_full (
    .clk_100MHz(clk_100MHz), .reset(reset), .pause(pause),
    .p_tick(f_p_tick), .x(f_x), .y(f_y), .video_on(f_video_on),
    .hsync(f_hsync), .vsync(f_vsync), .frame_tick(f_frame_tick),
    .game_tick(f_game_tick), .frame_count(f_frame_count)
  );

  typedef struct packed {
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_tick;
    logic       game_tick;
    logic [7:0] frame_count;
  } exp_t;

  typedef struct packed {
    logic       p_tick;
    logic [9:0] x;
  } vec_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, n, act, want);
    end
  endtask

  // Expected outputs after the k-th edge since reset release, derived from
  // the elapsed pixel count rather than from counter state.
  function automatic exp_t model(input int k, input logic pz);
    exp_t e;
    int   pix;
    logic adv;
    pix           = (k > DIV) ? (k - 1) / DIV : 0;
    adv           = (k > DIV) && ((k - 1) % DIV == 0);
    e.p_tick      = (k >= DIV) && (k % DIV == 0);
    e.x           = 10'(pix % HT);
    e.y           = 10'((pix / HT) % VT);
    e.video_on    = (int'(e.x) < HD) && (int'(e.y) < VD);
    e.hsync       = !((int'(e.x) >= HD + HF) && (int'(e.x) < HD + HF + HS));
    e.vsync       = !((int'(e.y) >= VD + VF) && (int'(e.y) < VD + VF + VS));
    e.frame_tick  = adv && (pix % FT == VB_PIX);
    e.game_tick   = e.frame_tick && !pz;
    e.frame_count = (pix >= VB_PIX) ? 8'(((pix - VB_PIX) / FT + 1) % 256) : 8'd0;
    return e;
  endfunction

  task automatic step();
    exp_t e;
    @(posedge clk_100MHz);
    if (reset) n = 0;
    else n++;
    sb_q.push_back(model(n, pause));
    #1;
    e = sb_q.pop_front();
    chk("p_tick", s_p_tick, e.p_tick);
    chk("x", s_x, e.x);
    chk("y", s_y, e.y);
    chk("video_on", s_video_on, e.video_on);
    chk("hsync", s_hsync, e.hsync);
    chk("vsync", s_vsync, e.vsync);
    chk("frame_tick", s_frame_tick, e.frame_tick);
    chk("game_tick", s_game_tick, e.game_tick);
    chk("frame_count", s_frame_count, e.frame_count);
  endtask

  initial begin
    vec_t vec[10];
    logic [9:0] prev_x, prev_v;
    int  hs_cnt, hs_first, vo_fall, wrap_y, vs_lines, ft_cnt, gt_cnt, ticks;
    logic found;

    vec[0] = '{1'b0, 10'd0}; vec[1] = '{1'b0, 10'd0};
    vec[2] = '{1'b0, 10'd0}; vec[3] = '{1'b1, 10'd0};
    vec[4] = '{1'b0, 10'd1}; vec[5] = '{1'b0, 10'd1};
    vec[6] = '{1'b0, 10'd1}; vec[7] = '{1'b1, 10'd1};
    vec[8] = '{1'b0, 10'd2}; vec[9] = '{1'b0, 10'd2};

    for (int i = 0; i < 3; i++) step();
    chk("full_rst_x", f_x, 10'd0);
    chk("full_rst_video_on", f_video_on, 1'b1);
    reset = 1'b0;

    // Post-release p_tick cadence and first counter steps.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("vec_p_tick", s_p_tick, vec[i].p_tick);
      chk("vec_x", s_x, vec[i].x);
    end

    // First full line on the full-size instance.
    prev_x = f_x; prev_v = {9'd0, f_video_on};
    hs_cnt = 0; hs_first = -1; vo_fall = -1; wrap_y = -1; vs_lines = 0;
    while (n < 3310) begin
      step();
      if (f_x != prev_x) begin
        if (!f_hsync) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(f_x);
        end
        if (prev_x == 10'd799 && f_x == 10'd0) wrap_y = int'(f_y);
      end
      if (prev_v[0] && !f_video_on && vo_fall < 0) vo_fall = int'(f_x);
      if (!s_vsync && s_x == 10'd0 && s_p_tick == 1'b0 && ((n - 1) % DIV == 0)) vs_lines++;
      prev_x = f_x; prev_v = {9'd0, f_video_on};
    end
    chk("full_hsync_width", hs_cnt, 96);
    chk("full_hsync_start_x", hs_first, 656);
    chk("full_video_on_fall_x", vo_fall, 640);
    chk("full_wrap_y", wrap_y, 1);

    // Pause for one whole frame, then run one unpaused.
    found = 1'b0;
    for (int i = 0; i < 2 * FT * DIV && !found; i++) begin
      step();
      if (s_frame_tick) found = 1'b1;
    end
    chk("frame_tick_seen", found, 1'b1);
    for (int ph = 0; ph < 2; ph++) begin
      pause = (ph == 0);
      ft_cnt = 0; gt_cnt = 0;
      for (int i = 0; i < FT * DIV; i++) begin
        step();
        if (s_frame_tick) ft_cnt++;
        if (s_game_tick) gt_cnt++;
      end
      chk("pause_frame_ticks", ft_cnt, 1);
      chk("pause_game_ticks", gt_cnt, (ph == 0) ? 0 : 1);
    end

    // Asynchronous reset in the middle of a frame.
    found = 1'b0;
    for (int i = 0; i < 2 * FT * DIV && !found; i++) begin
      step();
      if (s_x == 10'd5 && s_y == 10'd2) found = 1'b1;
    end
    chk("mid_frame_reached", found, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_x", s_x, 10'd0);
    chk("async_y", s_y, 10'd0);
    chk("async_p_tick", s_p_tick, 1'b0);
    chk("async_video_on", s_video_on, 1'b1);
    chk("async_hsync", s_hsync, 1'b1);
    chk("async_vsync", s_vsync, 1'b1);
    chk("async_frame_count", s_frame_count, 8'd0);
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("restart_x", s_x, 10'd1);
    chk("restart_frame_count", s_frame_count, 8'd0);

    // 256 frames: frame_count wraps exactly on the 256th frame_tick.
    ticks = 0;
    while (n < 71530) begin
      step();
      if (s_frame_tick) begin
        ticks++;
        chk("wrap_frame_count", s_frame_count, 32'(ticks % 256));
      end
    end
    chk("wrap_tick_total", ticks, 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
